// File: rtl/ysyx_22040632_dcache_flush_ctrl_pkg.sv
// Shared dcache constants and the flush controller state encoding.
package ysyx_22040632_dcache_flush_ctrl_pkg;

  localparam int SETS  = 32;
  localparam int TAG_W = 21;
  localparam int OFS_W = 6;

  // ptr = {way, index}; the last entry is way 1, set 31
  localparam int          PTR_W    = 6;
  localparam logic [5:0]  PTR_LAST = 6'd63;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    REQ   = 3'd2,
    WAIT  = 3'd3,
    CLEAR = 3'd4,
    DONE  = 3'd5
  } flush_state_t;

endpackage

// File: rtl/ysyx_22040632_dcache_flush_ctrl.sv
// Dcache flush (fence.i) controller: walks every {way, set} entry, writes back
// dirty lines through the writeback unit, then clears the tag array.
module ysyx_22040632_dcache_flush_ctrl
  import ysyx_22040632_dcache_flush_ctrl_pkg::*;
#(
  parameter int SETS  = ysyx_22040632_dcache_flush_ctrl_pkg::SETS,
  parameter int TAG_W = ysyx_22040632_dcache_flush_ctrl_pkg::TAG_W,
  parameter int OFS_W = ysyx_22040632_dcache_flush_ctrl_pkg::OFS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_req,
  input  logic [SETS-1:0]   dirty_array_1st,
  input  logic [SETS-1:0]   dirty_array_2nd,
  input  logic [TAG_W-1:0]  tag_read,
  output logic [4:0]        scan_index,
  output logic              scan_way,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [31:0]       wb_addr,
  output logic              wb_way,
  input  logic              wb_done,
  output logic              flush_tag_f,
  output logic              busy,
  output logic              flush_done
);

  flush_state_t     state_reg, state_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic             dirty_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    wb_valid    = 1'b0;
    flush_tag_f = 1'b0;
    flush_done  = 1'b0;
    busy        = (state_reg != IDLE);
    scan_index  = ptr_reg[4:0];
    scan_way    = ptr_reg[5];
    wb_way      = ptr_reg[5];
    wb_addr     = {tag_read, ptr_reg[4:0], {OFS_W{1'b0}}};
    // Dirty bits are looked at live; nothing is cached across the scan
    dirty_sel   = ptr_reg[5] ? dirty_array_2nd[ptr_reg[4:0]]
                             : dirty_array_1st[ptr_reg[4:0]];

    unique case (state_reg)
      IDLE: begin
        if (flush_req) begin
          ptr_next   = '0;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (dirty_sel)
          state_next = REQ;
        else if (ptr_reg == PTR_LAST)
          state_next = CLEAR;
        else
          ptr_next = ptr_reg + 1'b1;
      end
      REQ: begin
        wb_valid = 1'b1;
        if (wb_ready)
          state_next = WAIT;
      end
      WAIT: begin
        if (wb_done) begin
          if (ptr_reg == PTR_LAST) begin
            state_next = CLEAR;
          end else begin
            ptr_next   = ptr_reg + 1'b1;
            state_next = SCAN;
          end
        end
      end
      CLEAR: begin
        flush_tag_f = 1'b1;
        state_next  = DONE;
      end
      DONE: begin
        flush_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22040632_dcache_flush_ctrl.sv
// Directed bench for the dcache flush controller; cycle numbers in the
// comments count from the edge that samples flush_req (edge 0).
module tb_ysyx_22040632_dcache_flush_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_req;
  logic [31:0] dirty_array_1st;
  logic [31:0] dirty_array_2nd;
  logic [20:0] tag_read;
  logic [4:0]  scan_index;
  logic        scan_way;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_addr;
  logic        wb_way;
  logic        wb_done;
  logic        flush_tag_f;
  logic        busy;
  logic        flush_done;

  logic [20:0] tag_mem [0:63];
  int n_checks = 0;
  int n_fail   = 0;

  ysyx_22040632_dcache_flush_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .flush_req       (flush_req),
    .dirty_array_1st (dirty_array_1st),
    .dirty_array_2nd (dirty_array_2nd),
    .tag_read        (tag_read),
    .scan_index      (scan_index),
    .scan_way        (scan_way),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .wb_addr         (wb_addr),
    .wb_way          (wb_way),
    .wb_done         (wb_done),
    .flush_tag_f     (flush_tag_f),
    .busy            (busy),
    .flush_done      (flush_done)
  );

  always #5 clk = ~clk;

  // Tag array read port model
  always_comb tag_read = tag_mem[{scan_way, scan_index}];

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns in the middle of cycle 1
  task automatic start_flush();
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
  endtask

  task automatic clear_env();
    dirty_array_1st = '0;
    dirty_array_2nd = '0;
    wb_ready = 1'b0;
    wb_done  = 1'b0;
    flush_req = 1'b0;
    for (int i = 0; i < 64; i++) tag_mem[i] = '0;
  endtask

  // Advances until flush_done, counting cycles and flush_tag_f pulses seen
  task automatic wait_done(input int exp_cycles, input string name);
    int n = 0;
    int tags = 0;
    while (flush_done !== 1'b1 && n < 300) begin
      if (flush_tag_f === 1'b1) tags++;
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n !== exp_cycles) begin
      n_fail++;
      $display("FAIL %s_done_latency: got %0d cycles, expected %0d", name, n, exp_cycles);
    end
    n_checks++;
    if (tags !== 1) begin
      n_fail++;
      $display("FAIL %s_tag_pulses: got %0d, expected 1", name, tags);
    end
    step(1);
    n_checks++;
    if (busy !== 1'b0 || flush_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_after: busy=%b flush_done=%b, expected 0 0", name, busy, flush_done);
    end
    $display("txn %s: flush completed after %0d cycles", name, n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_env();
    step(2);
    n_checks++;
    if ({busy, wb_valid, flush_tag_f, flush_done, scan_way, scan_index} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b wb_valid=%b tag_f=%b done=%b way=%b idx=%0d, expected all 0",
               busy, wb_valid, flush_tag_f, flush_done, scan_way, scan_index);
    end
    rst = 1'b0;
    step(1);
    $display("txn reset: outputs checked");
  endtask

  task automatic test_clean();
    logic [5:0] exp_ptr;
    clear_env();
    start_flush();
    for (int k = 0; k < 64; k++) begin
      exp_ptr = 6'(k);
      n_checks++;
      if ({scan_way, scan_index} !== exp_ptr || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL clean_scan_ptr: got ptr=%0d busy=%b, expected ptr=%0d busy=1",
                 {scan_way, scan_index}, busy, exp_ptr);
      end
      n_checks++;
      if (wb_valid !== 1'b0 || flush_tag_f !== 1'b0) begin
        n_fail++;
        $display("FAIL clean_scan_quiet: wb_valid=%b tag_f=%b at cycle %0d, expected 0 0",
                 wb_valid, flush_tag_f, k + 1);
      end
      step(1);
    end
    n_checks++;
    if (flush_tag_f !== 1'b1 || flush_done !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_cycle65: tag_f=%b done=%b, expected 1 0", flush_tag_f, flush_done);
    end
    step(1);
    n_checks++;
    if (flush_done !== 1'b1 || flush_tag_f !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_cycle66: done=%b tag_f=%b busy=%b, expected 1 0 1", flush_done, flush_tag_f, busy);
    end
    step(1);
    n_checks++;
    if (busy !== 1'b0 || flush_done !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_cycle67: busy=%b done=%b, expected 0 0", busy, flush_done);
    end
    $display("txn clean: 64 scan cycles, clear at 65, done at 66");
  endtask

  task automatic test_dirty_set3();
    clear_env();
    tag_mem[3] = 21'h1ABCD;
    dirty_array_1st[3] = 1'b1;
    start_flush();
    step(3);                       // cycle 4: SCAN ptr 3
    n_checks++;
    if (scan_index !== 5'd3 || wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL set3_scan: idx=%0d wb_valid=%b, expected 3 0", scan_index, wb_valid);
    end
    step(1);                       // cycle 5: REQ
    for (int c = 5; c < 8; c++) begin
      n_checks++;
      if (wb_valid !== 1'b1 || wb_addr !== 32'h0D5E_68C0 || wb_way !== 1'b0) begin
        n_fail++;
        $display("FAIL set3_req: valid=%b addr=%h way=%b, expected 1 0d5e68c0 0", wb_valid, wb_addr, wb_way);
      end
      step(1);
    end
    wb_ready = 1'b1;               // cycle 8: handshake
    step(1);
    wb_ready = 1'b0;               // cycle 9: WAIT
    n_checks++;
    if (wb_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL set3_wait: wb_valid=%b busy=%b, expected 0 1", wb_valid, busy);
    end
    step(4);                       // cycle 13
    n_checks++;
    if (scan_index !== 5'd3) begin
      n_fail++;
      $display("FAIL set3_hold: idx=%0d, expected 3", scan_index);
    end
    wb_done = 1'b1;
    step(1);                       // cycle 14: SCAN ptr 4
    wb_done = 1'b0;
    dirty_array_1st[3] = 1'b0;
    n_checks++;
    if (scan_index !== 5'd4 || scan_way !== 1'b0 || wb_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL set3_resume: idx=%0d way=%b valid=%b busy=%b, expected 4 0 0 1",
               scan_index, scan_way, wb_valid, busy);
    end
    wait_done(61, "set3");
  endtask

  task automatic test_last_entry();
    int n = 0;
    clear_env();
    dirty_array_2nd[31] = 1'b1;
    start_flush();
    while (wb_valid !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    n_checks++;
    if (n !== 64) begin
      n_fail++;
      $display("FAIL last_req_latency: got %0d cycles, expected 64", n);
    end
    n_checks++;
    if (wb_addr !== 32'h0000_07C0 || wb_way !== 1'b1) begin
      n_fail++;
      $display("FAIL last_req_addr: addr=%h way=%b, expected 000007c0 1", wb_addr, wb_way);
    end
    wb_ready = 1'b1;
    step(1);                       // WAIT
    wb_ready = 1'b0;
    wb_done  = 1'b1;
    step(1);                       // CLEAR, ptr must stay at 63
    wb_done  = 1'b0;
    dirty_array_2nd[31] = 1'b0;
    n_checks++;
    if (flush_tag_f !== 1'b1 || scan_index !== 5'd31 || scan_way !== 1'b1) begin
      n_fail++;
      $display("FAIL last_clear: tag_f=%b idx=%0d way=%b, expected 1 31 1", flush_tag_f, scan_index, scan_way);
    end
    step(1);
    n_checks++;
    if (flush_done !== 1'b1) begin
      n_fail++;
      $display("FAIL last_done: done=%b, expected 1", flush_done);
    end
    step(1);
    $display("txn last_entry: addr 000007c0 way 1 written back, no wrap");
  endtask

  task automatic test_stall();
    clear_env();
    tag_mem[0] = 21'h155555;
    dirty_array_1st[0] = 1'b1;
    start_flush();
    step(1);                       // cycle 2: REQ
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (wb_valid !== 1'b1 || wb_addr !== 32'hAAAA_A800 || wb_way !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: valid=%b addr=%h way=%b, expected 1 aaaaa800 0", wb_valid, wb_addr, wb_way);
      end
      step(1);
    end
    wb_ready = 1'b1;               // cycle 12
    step(1);
    wb_ready = 1'b0;
    wb_done  = 1'b1;               // cycle 13: WAIT
    step(1);
    wb_done  = 1'b0;
    dirty_array_1st[0] = 1'b0;     // cycle 14: SCAN ptr 1
    wait_done(64, "stall");
  endtask

  task automatic test_ignored();
    int extra = 0;
    clear_env();
    dirty_array_1st[5] = 1'b1;
    start_flush();
    step(1);                       // cycle 2: SCAN ptr 1, spurious wb_done
    wb_done = 1'b1;
    step(1);
    wb_done = 1'b0;
    n_checks++;
    if (scan_index !== 5'd2 || wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_wbdone: idx=%0d valid=%b, expected 2 0", scan_index, wb_valid);
    end
    step(4);                       // cycle 7: REQ
    wb_ready = 1'b1;
    step(1);                       // cycle 8: WAIT
    wb_ready  = 1'b0;
    flush_req = 1'b1;
    step(2);                       // cycle 10
    flush_req = 1'b0;
    n_checks++;
    if (scan_index !== 5'd5 || busy !== 1'b1 || wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_req_wait: idx=%0d busy=%b valid=%b, expected 5 1 0", scan_index, busy, wb_valid);
    end
    wb_done = 1'b1;
    step(1);                       // cycle 11: SCAN ptr 6
    wb_done = 1'b0;
    dirty_array_1st[5] = 1'b0;
    wait_done(59, "ignore");
    for (int c = 0; c < 5; c++) begin
      if (flush_done === 1'b1 || busy === 1'b1) extra++;
      step(1);
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL ignore_no_second: got %0d busy/done cycles, expected 0", extra);
    end
  endtask

  task automatic test_reset_in_wait();
    int pulses = 0;
    clear_env();
    dirty_array_1st[7] = 1'b1;
    start_flush();
    step(8);                       // cycle 9: REQ
    wb_ready = 1'b1;
    step(1);                       // cycle 10: WAIT
    wb_ready = 1'b0;
    n_checks++;
    if (scan_index !== 5'd7 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstwait_pre: idx=%0d busy=%b, expected 7 1", scan_index, busy);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    dirty_array_1st[7] = 1'b0;
    n_checks++;
    if ({busy, wb_valid, flush_tag_f, flush_done, scan_way, scan_index} !== 10'd0) begin
      n_fail++;
      $display("FAIL rstwait_outputs: busy=%b valid=%b tag_f=%b done=%b way=%b idx=%0d, expected all 0",
               busy, wb_valid, flush_tag_f, flush_done, scan_way, scan_index);
    end
    for (int c = 0; c < 5; c++) begin
      if (flush_tag_f === 1'b1 || flush_done === 1'b1) pulses++;
      step(1);
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL rstwait_no_pulse: got %0d pulses, expected 0", pulses);
    end
    $display("txn reset_in_wait: flush aborted");
  endtask

  task automatic test_back_to_back();
    clear_env();
    tag_mem[3] = 21'h1ABCD0;
    tag_mem[4] = 21'h1ABCD;
    dirty_array_1st[3] = 1'b1;
    dirty_array_1st[4] = 1'b1;
    wb_ready = 1'b1;
    start_flush();
    step(4);                       // cycle 5: REQ set 3
    n_checks++;
    if (wb_valid !== 1'b1 || wb_addr !== 32'hD5E6_80C0) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%b addr=%h, expected 1 d5e680c0", wb_valid, wb_addr);
    end
    step(1);                       // cycle 6: WAIT
    wb_done = 1'b1;
    step(1);                       // cycle 7: SCAN ptr 4
    wb_done = 1'b0;
    dirty_array_1st[3] = 1'b0;
    step(1);                       // cycle 8: REQ set 4
    n_checks++;
    if (wb_valid !== 1'b1 || wb_addr !== 32'h0D5E_6900) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%b addr=%h, expected 1 0d5e6900", wb_valid, wb_addr);
    end
    step(1);                       // cycle 9: WAIT
    wb_done = 1'b1;
    step(1);                       // cycle 10: SCAN ptr 5
    wb_done = 1'b0;
    wb_ready = 1'b0;
    dirty_array_1st[4] = 1'b0;
    wait_done(60, "b2b");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean();
    test_dirty_set3();
    test_last_entry();
    test_stall();
    test_ignored();
    test_reset_in_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
